// File: rtl/alu_seq_exec.sv
// alu_seq_exec: execute-stage ALU with one-cycle logic/arith/compare ops and
// iterative one-bit-per-cycle shifts behind valid/ready handshakes.  Rev 1.0
`default_nettype none

module alu_seq_exec #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            alu_control,
  input  logic [DATA_WIDTH-1:0] src_a,
  input  logic [DATA_WIDTH-1:0] src_b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  zero,
  output logic                  busy
);

  localparam int SHAMT_W = $clog2(DATA_WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] acc;
  logic [DATA_WIDTH-1:0] acc_next;
  logic [DATA_WIDTH-1:0] alu_out;
  logic [SHAMT_W-1:0]    cnt;
  logic [SHAMT_W-1:0]    shamt;
  logic [1:0]            shift_op;
  logic                  is_shift;

  assign shamt     = src_b[SHAMT_W-1:0];
  assign is_shift  = (alu_control == 4'b0101) || (alu_control == 4'b0110) ||
                     (alu_control == 4'b0111);
  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign out_valid = (state == DONE);

  always_comb begin
    alu_out = '0;
    case (alu_control)
      4'b0000: alu_out = src_a + src_b;
      4'b0001: alu_out = src_a - src_b;
      4'b0010: alu_out = src_a & src_b;
      4'b0011: alu_out = src_a | src_b;
      4'b0100: alu_out = src_a ^ src_b;
      4'b1000: alu_out = {{(DATA_WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      4'b1001: alu_out = {{(DATA_WIDTH-1){1'b0}}, (src_a < src_b)};
      default: alu_out = '0;
    endcase
  end

  // shift_op holds alu_control[1:0]: 01 SLL, 10 SRL, 11 SRA
  always_comb begin
    acc_next = acc;
    case (shift_op)
      2'b01:   acc_next = {acc[DATA_WIDTH-2:0], 1'b0};
      2'b10:   acc_next = {1'b0, acc[DATA_WIDTH-1:1]};
      default: acc_next = {acc[DATA_WIDTH-1], acc[DATA_WIDTH-1:1]};
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      acc      <= '0;
      cnt      <= '0;
      shift_op <= 2'b00;
      result   <= '0;
      zero     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (is_shift && (shamt != '0)) begin
              acc      <= src_a;
              cnt      <= shamt;
              shift_op <= alu_control[1:0];
              state    <= SHIFT;
            end else if (is_shift) begin
              result <= src_a;
              zero   <= (src_a == '0);
              state  <= DONE;
            end else begin
              result <= alu_out;
              zero   <= (alu_out == '0);
              state  <= DONE;
            end
          end
        end
        SHIFT: begin
          acc <= acc_next;
          cnt <= cnt - SHAMT_W'(1);
          if (cnt == SHAMT_W'(1)) begin
            result <= acc_next;
            zero   <= (acc_next == '0);
            state  <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_seq_exec.sv
// tb_alu_seq_exec: randomized and directed bench for alu_seq_exec against a
// plain-arithmetic reference model.  Rev 1.0
`default_nettype none

module tb_alu_seq_exec;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  alu_control = 4'd0;
  logic [31:0] src_a = '0;
  logic [31:0] src_b = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic        zero;
  logic        busy;

  int tests = 0;
  int fails = 0;

  alu_seq_exec #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .alu_control(alu_control), .src_a(src_a), .src_b(src_b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .zero(zero), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    int sh;
    sh = int'(b[4:0]);
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return a << sh;
      4'd6: return a >> sh;
      4'd7: return 32'($signed(a) >>> sh);
      4'd8: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd9: return (a < b) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  function automatic int ref_lat(input logic [3:0] op, input logic [31:0] b);
    if ((op >= 4'd5) && (op <= 4'd7) && (b[4:0] != 5'd0)) return int'(b[4:0]) + 1;
    return 1;
  endfunction

  // Issue one op; returns at the first falling edge where out_valid is seen.
  task automatic exec(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic rdy, output logic [31:0] r, output logic z,
                      output int lat, output logic busy_all);
    int guard;
    guard = 0;
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    out_ready   = rdy;
    alu_control = op;
    src_a       = a;
    src_b       = b;
    in_valid    = 1'b1;
    @(posedge clk);
    #1;
    in_valid    = 1'b0;
    src_a       = $urandom;
    src_b       = $urandom;
    alu_control = 4'($urandom);
    lat      = 0;
    busy_all = 1'b1;
    do begin
      @(negedge clk);
      lat++;
      if (!busy) busy_all = 1'b0;
    end while (!out_valid && lat < 200);
    if (!out_valid) lat = 999;
    r = result;
    z = zero;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    tests++;
    if ({in_ready, out_valid, busy, zero} !== 4'b1000 || result !== 32'd0) begin
      fails++;
      $display("FAIL reset: in_ready/out_valid/busy/zero=%b result=%h, want 1000 / 0",
               {in_ready, out_valid, busy, zero}, result);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_arith();
    logic [31:0] r;
    logic z, b;
    int lat;
    exec(4'd0, 32'd5, 32'd7, 1'b1, r, z, lat, b);
    tests++;
    if (r !== 32'd12 || z !== 1'b0 || lat !== 1) begin
      fails++;
      $display("FAIL add: result=%h zero=%b lat=%0d, want 0000000c 0 1", r, z, lat);
    end
    @(negedge clk);
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL add_pulse: out_valid=%b in_ready=%b, want 0 1", out_valid, in_ready);
    end
    exec(4'd1, 32'd3, 32'd3, 1'b1, r, z, lat, b);
    tests++;
    if (r !== 32'd0 || z !== 1'b1 || lat !== 1) begin
      fails++;
      $display("FAIL sub: result=%h zero=%b lat=%0d, want 0 1 1", r, z, lat);
    end
  endtask

  task automatic test_compare();
    logic [31:0] r;
    logic z, b;
    int lat;
    exec(4'd8, 32'hFFFF_FFFF, 32'd1, 1'b1, r, z, lat, b);
    tests++;
    if (r !== 32'd1 || z !== 1'b0) begin
      fails++;
      $display("FAIL slt: result=%h zero=%b, want 1 0", r, z);
    end
    exec(4'd9, 32'hFFFF_FFFF, 32'd1, 1'b1, r, z, lat, b);
    tests++;
    if (r !== 32'd0 || z !== 1'b1) begin
      fails++;
      $display("FAIL sltu: result=%h zero=%b, want 0 1", r, z);
    end
    exec(4'b1100, 32'h1234_5678, 32'h9abc_def0, 1'b1, r, z, lat, b);
    tests++;
    if (r !== 32'd0 || z !== 1'b1 || lat !== 1) begin
      fails++;
      $display("FAIL unused_code: result=%h zero=%b lat=%0d, want 0 1 1", r, z, lat);
    end
  endtask

  task automatic test_shift();
    logic [31:0] r;
    logic z, b;
    int lat;
    exec(4'd7, 32'h8000_0000, 32'd4, 1'b1, r, z, lat, b);
    tests++;
    if (r !== 32'hF800_0000 || lat !== 5 || b !== 1'b1) begin
      fails++;
      $display("FAIL sra: result=%h lat=%0d busy=%b, want f8000000 5 1", r, lat, b);
    end
    exec(4'd6, 32'h8000_0000, 32'd4, 1'b1, r, z, lat, b);
    tests++;
    if (r !== 32'h0800_0000 || lat !== 5) begin
      fails++;
      $display("FAIL srl: result=%h lat=%0d, want 08000000 5", r, lat);
    end
    exec(4'd5, 32'd1, 32'd31, 1'b1, r, z, lat, b);
    tests++;
    if (r !== 32'h8000_0000 || lat !== 32) begin
      fails++;
      $display("FAIL sll31: result=%h lat=%0d, want 80000000 32", r, lat);
    end
    exec(4'd5, 32'h1234, 32'h20, 1'b1, r, z, lat, b);
    tests++;
    if (r !== 32'h1234 || lat !== 1) begin
      fails++;
      $display("FAIL shamt0: result=%h lat=%0d, want 00001234 1", r, lat);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] r;
    logic z, b;
    int lat;
    exec(4'd0, 32'd100, 32'd23, 1'b0, r, z, lat, b);
    in_valid    = 1'b1;
    alu_control = 4'd1;
    src_a       = 32'd7;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      tests++;
      if (result !== 32'd123 || zero !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
        fails++;
        $display("FAIL hold[%0d]: result=%h zero=%b in_ready=%b out_valid=%b, want 7b 0 0 1",
                 i, result, zero, in_ready, out_valid);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL release: in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] r;
    logic z, b, saw;
    int lat;
    alu_control = 4'd5;
    src_a       = 32'd1;
    src_b       = 32'd20;
    out_ready   = 1'b1;
    in_valid    = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tests++;
    if (out_valid !== 1'b0 || result !== 32'd0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL rst_mid: out_valid=%b result=%h busy=%b in_ready=%b, want 0 0 0 1",
               out_valid, result, busy, in_ready);
    end
    saw = 1'b0;
    repeat (25) begin
      @(negedge clk);
      if (out_valid) saw = 1'b1;
    end
    tests++;
    if (saw !== 1'b0) begin
      fails++;
      $display("FAIL rst_abort: out_valid seen=%b, want 0", saw);
    end
    exec(4'd0, 32'd1, 32'd1, 1'b1, r, z, lat, b);
    tests++;
    if (r !== 32'd2 || z !== 1'b0 || lat !== 1) begin
      fails++;
      $display("FAIL post_rst_add: result=%h zero=%b lat=%0d, want 2 0 1", r, z, lat);
    end
  endtask

  task automatic test_random();
    logic [31:0] r, a, bb, exp;
    logic z, b;
    logic [3:0] op;
    int lat;
    for (int i = 0; i < 80; i++) begin
      op  = 4'($urandom_range(0, 15));
      a   = $urandom;
      bb  = $urandom;
      if ($urandom_range(0, 3) == 0) a = bb;
      exp = ref_alu(op, a, bb);
      exec(op, a, bb, 1'b1, r, z, lat, b);
      tests++;
      if (r !== exp || z !== (exp == 32'd0) || lat !== ref_lat(op, bb)) begin
        fails++;
        $display("FAIL rand[%0d] op=%0d a=%h b=%h: result=%h zero=%b lat=%0d, want %h %b %0d",
                 i, op, a, bb, r, z, lat, exp, (exp == 32'd0), ref_lat(op, bb));
      end
    end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_compare();
    test_shift();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
